// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 word type, round constants, IV, FSM states and helper functions
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    // H0..H7 packed with H0 in the top word, matching the digest layout.
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t ep0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t ep1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
// Ports:
//   i_state [255:0] : a..h, a in bits [255:224]
//   i_k             : round constant K[t]
//   i_w             : schedule word W[t]
//   o_state [255:0] : next a..h, same layout
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  word_t        i_k,
    input  word_t        i_w,
    output logic [255:0] o_state
);

    word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    word_t w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    // All sums wrap at 32 bits by construction of word_t.
    assign w_t1 = w_h + ep1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = ep0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_mb_core.sv
// rtl/sha256_mb_core.sv - multi-block SHA-256 compression core, UNROLL rounds per cycle
// Optional feature macro: SHA256_MIDSTATE_EN (adds in_midstate, used when in_first=1).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   in_valid/ready : block handshake; in_ready only in IDLE
//   in_block[511:0]: padded block, word 0 in [511:480]
//   in_first       : 1 starts a new message, 0 chains from the held digest
//   in_midstate    : (SHA256_MIDSTATE_EN only) starting state for in_first=1
//   out_valid/ready: digest handshake
//   out_digest     : H0..H7, H0 in [255:224]
module sha256_mb_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
`ifdef SHA256_MIDSTATE_EN
    input  logic [255:0] in_midstate,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest
);

    localparam int          ROUND_CYCLES = 64 / UNROLL;
    localparam logic [6:0]  CNT_LAST     = 7'(ROUND_CYCLES);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
            $error("sha256_mb_core: UNROLL must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t       r_state;
    state_t       w_next;
    logic [6:0]   r_cnt;
    logic [255:0] r_work;
    logic [255:0] r_start;
    logic [255:0] r_chain;
    logic [255:0] r_digest;
    word_t        r_w [16];

    word_t        w_ext [16+UNROLL];
    logic [255:0] w_init;
    logic [255:0] w_sum;
    logic [255:0] w_rounds_out;
    logic [5:0]   w_t_base;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)          w_next = ROUND;
            // The counter parks at CNT_LAST for one cycle with the round
            // logic idle, so FINAL always reads settled a..h.
            ROUND:   if (r_cnt == CNT_LAST) w_next = FINAL;
            FINAL:                          w_next = OUT;
            OUT:     if (out_ready)         w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == OUT);
    end

    // ---------------- starting state select ----------------
`ifdef SHA256_MIDSTATE_EN
    assign w_init = in_first ? in_midstate : r_chain;
`else
    assign w_init = in_first ? IV : r_chain;
`endif

    // ---------------- message schedule ----------------
    // w_ext holds W[t..t+15] from the window followed by the UNROLL new words
    // W[t+16..]; later new words depend on earlier ones, hence the ordered loop.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            w_ext[16+j] = sig1(w_ext[14+j]) + w_ext[9+j] + sig0(w_ext[1+j]) + w_ext[j];
        end
    end

    // ---------------- round chain ----------------
    assign w_t_base = r_cnt[5:0] * 6'(UNROLL);

    generate
        for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
            logic [255:0] w_in;
            logic [255:0] w_out;
            logic [5:0]   w_kidx;

            if (j == 0) begin : g_first
                assign w_in = r_work;
            end else begin : g_next
                assign w_in = g_rnd[j-1].w_out;
            end

            assign w_kidx = w_t_base + 6'(j);

            sha256_round u_round (
                .i_state (w_in),
                .i_k     (K[w_kidx]),
                .i_w     (w_ext[j]),
                .o_state (w_out)
            );
        end
    endgenerate

    assign w_rounds_out = g_rnd[UNROLL-1].w_out;

    // ---------------- final add ----------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum[255-32*i -: 32] = r_work[255-32*i -: 32] + r_start[255-32*i -: 32];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_start  <= '0;
            r_chain  <= IV;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= in_block[511-32*i -: 32];
                        end
                        r_work  <= w_init;
                        r_start <= w_init;
                        r_cnt   <= '0;
                    end
                end
                ROUND: begin
                    if (r_cnt != CNT_LAST) begin
                        r_work <= w_rounds_out;
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= w_ext[i+UNROLL];
                        end
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                FINAL: begin
                    r_chain  <= w_sum;
                    r_digest <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign out_digest = r_digest;

endmodule

// File: tb/tb_sha256_mb_core.sv
// tb/tb_sha256_mb_core.sv - directed scoreboard bench for sha256_mb_core
module tb_sha256_mb_core;

    localparam logic [511:0] ABC_BLK   = {24'h616263, 8'h80, 416'h0, 64'd24};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 440'h0, 64'd0};
    localparam logic [511:0] TWO_BLK1  = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0};
    localparam logic [511:0] TWO_BLK2  = {448'h0, 64'd448};

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [255:0] dig;
        bit           chk;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;

    logic         aux_valid;
    logic         aux_ready [3];
    logic         aux_ov    [3];
    logic [255:0] aux_dig   [3];

    exp_t sb_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sha256_mb_core #(.UNROLL(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_first   (in_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest)
    );

    generate
        for (genvar g = 0; g < 3; g++) begin : g_aux
            sha256_mb_core #(.UNROLL(2 << g)) u_aux (
                .clk        (clk),
                .reset      (reset),
                .in_valid   (aux_valid),
                .in_ready   (aux_ready[g]),
                .in_block   (in_block),
                .in_first   (1'b1),
                .out_valid  (aux_ov[g]),
                .out_ready  (1'b1),
                .out_digest (aux_dig[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input string tag, input logic [511:0] blk, input logic first,
                        input logic [255:0] dig, input bit do_chk, input bit push);
        exp_t e;
        chk({tag, "_in_ready_before"}, 256'(in_ready), 256'(1));
        in_block = blk;
        in_first = first;
        in_valid = 1'b1;
        if (push) begin
            e.dig = dig;
            e.chk = do_chk;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects out_ready=1: waits for the digest, checks latency and value,
    // then checks the core is back in IDLE one cycle later.
    task automatic receive(input string tag, input int lat);
        int   cyc = 0;
        exp_t e;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 256'(cyc), 256'(lat));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk) chk({tag, "_digest"}, out_digest, e.dig);
        end else begin
            chk({tag, "_scoreboard_entry"}, 256'(0), 256'(1));
        end
        @(negedge clk);
        chk({tag, "_out_valid_drop"}, 256'(out_valid), 256'(0));
        chk({tag, "_in_ready_after"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        int           lat_m;
        logic [255:0] dig_m;
        logic         rdy_after;
        logic         ov_after;
        int           aux_lat [3];
        logic [255:0] aux_d   [3];
        int           seen;
        exp_t         e;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        aux_valid = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_out_valid",  256'(out_valid), 256'(0));
        chk("rst_out_digest", out_digest, 256'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        for (int g = 0; g < 3; g++) chk($sformatf("rst_aux%0d_in_ready", g), 256'(aux_ready[g]), 256'(1));

        // ---- "abc" on all unroll factors, out_ready already high ----
        lat_m     = -1;
        dig_m     = '0;
        rdy_after = 1'b0;
        ov_after  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            aux_lat[g] = -1;
            aux_d[g]   = '0;
        end
        aux_valid = 1'b1;
        send("abc", ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b1);
        aux_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (out_valid && lat_m < 0) begin
                lat_m = cyc;
                dig_m = out_digest;
            end else if (lat_m > 0 && cyc == lat_m + 1) begin
                rdy_after = in_ready;
                ov_after  = out_valid;
            end
            for (int g = 0; g < 3; g++) begin
                if (aux_ov[g] && aux_lat[g] < 0) begin
                    aux_lat[g] = cyc;
                    aux_d[g]   = aux_dig[g];
                end
            end
        end
        chk("abc_latency", 256'(lat_m), 256'(66));
        e = sb_q.pop_front();
        chk("abc_digest", dig_m, e.dig);
        chk("abc_in_ready_after", 256'(rdy_after), 256'(1));
        chk("abc_out_valid_drop", 256'(ov_after), 256'(0));
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("abc_u%0d_latency", 2 << g), 256'(aux_lat[g]), 256'(64 / (2 << g) + 2));
            chk($sformatf("abc_u%0d_digest", 2 << g), aux_d[g], ABC_DIG);
        end

        // ---- empty string ----
        send("empty", EMPTY_BLK, 1'b1, EMPTY_DIG, 1'b1, 1'b1);
        receive("empty", 66);

        // ---- two-block message ----
        send("two1", TWO_BLK1, 1'b1, '0, 1'b0, 1'b1);
        receive("two1", 66);
        send("two2", TWO_BLK2, 1'b0, TWO_DIG, 1'b1, 1'b1);
        receive("two2", 66);

        // ---- backpressure, with a stray in_valid while in OUT ----
        out_ready = 1'b0;
        send("bp", ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b1);
        begin
            int cyc = 0;
            while (!out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("bp_latency", 256'(cyc), 256'(66));
        end
        e = sb_q.pop_front();
        chk("bp_digest", out_digest, e.dig);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k == 3);
            in_block = EMPTY_BLK;
            @(negedge clk);
            chk($sformatf("bp_hold%0d_digest", k), out_digest, e.dig);
            chk($sformatf("bp_hold%0d_out_valid", k), 256'(out_valid), 256'(1));
            chk($sformatf("bp_hold%0d_in_ready", k), 256'(in_ready), 256'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 256'(out_valid), 256'(0));
        chk("bp_release_in_ready",  256'(in_ready),  256'(1));
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp_stray_ignored", 256'(seen), 256'(0));

        // ---- reset in the middle of the rounds ----
        send("abort", EMPTY_BLK, 1'b1, '0, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready",   256'(in_ready), 256'(1));
        chk("abort_out_digest", out_digest, 256'(0));
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_digest", 256'(seen), 256'(0));

        // ---- recovery: chain register is back to the IV ----
        send("recover", ABC_BLK, 1'b0, ABC_DIG, 1'b1, 1'b1);
        receive("recover", 66);

        chk("scoreboard_empty", 256'(sb_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha256_mb_core.md
SHA256_MB_CORE -- requirements
Module: sha256_mb_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1: rounds per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_block and in_first are valid.
REQ-005 SHALL have port in_ready  output  1  block accepted when in_valid && in_ready.
REQ-006 SHALL have port in_block  input  512  padded message block; word 0 in bits [511:480].
REQ-007 SHALL have port in_first  input  1  1: start a new message; 0: chain from the held digest.
REQ-008 SHALL have port out_valid  output  1  out_digest is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the digest when out_valid && out_ready.
REQ-010 SHALL have port out_digest  output  256  H0..H7; H0 in bits [255:224].

Function
REQ-011 SHALL implement FSM states IDLE, ROUND, FINAL, OUT.
REQ-012 SHALL assert in_ready only in IDLE (registered state decode; no combinational path from in_valid).
REQ-013 On accept: SHALL capture in_block into a 16-word schedule window, load a..h from the init state (REQ-019) or the chain register, clear the round counter, and go to ROUND.
REQ-014 ROUND: SHALL perform UNROLL chained rounds per cycle for 64/UNROLL cycles, then go to FINAL.
REQ-015 SHALL compute W[t] for t >= 16 on the fly: sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], mod 2^32, in the sliding window; no 64-word array.
REQ-016 FINAL: SHALL add a..h word-wise mod 2^32 to the block's starting state, write the result to the chain register and out_digest, and go to OUT.
REQ-017 OUT: SHALL hold out_valid=1 and out_digest stable until out_ready; on handshake, go to IDLE next cycle.
REQ-018 Latency: SHALL assert out_valid exactly 64/UNROLL + 2 cycles after the accepting edge (UNROLL=1: 66; UNROLL=4: 18).
REQ-019 in_first=1: SHALL use the SHA-256 IV as the init state; in_first=0 directly after reset SHALL use the chain register's reset value (the IV).
REQ-020 out_ready=1 already when out_valid rises: SHALL complete the handshake that cycle; in_ready=1 on the next cycle.
REQ-021 in_valid while not in IDLE: SHALL be ignored, with no state change.
REQ-022 All additions SHALL be 32-bit modulo 2^32, with carries discarded.

Reset
REQ-023 On reset: state=IDLE, in_ready=1 on the following cycle, out_valid=0, out_digest=0, round counter=0, chain register=IV, working registers=0.
REQ-024 Reset in any state SHALL abandon the block in progress; no digest is emitted for it.

Configuration
REQ-025 With SHA256_MIDSTATE_EN defined: SHALL add port in_midstate, input, 256 bits; in_first=1 then loads a..h and the starting state from in_midstate instead of the IV.
REQ-026 Without SHA256_MIDSTATE_EN: SHALL omit in_midstate; in_first=1 uses the IV.

Structure
REQ-027 Package sha256_pkg SHALL hold word_t (32-bit) and the K[0:63] constant table.
REQ-028 sha256_pkg SHALL also hold the IV constants, the state_t enum, and the functions rotr, ch, maj, ep0, ep1, sig0, sig1.
REQ-029 Sub-module sha256_round SHALL be combinational: one compression round taking a..h, K[t] and W[t], producing the next a..h.
REQ-030 sha256_mb_core SHALL instantiate sha256_round UNROLL times in a chain.

Verification
REQ-031 "abc" single padded block, in_first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, at cycle 66 (UNROLL=1).
REQ-032 Empty string padded block -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-033 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks (in_first=1 then in_first=0) -> second digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid -> digest stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset pulsed at round 30 -> out_valid never asserts for that block.
REQ-036 Reset recovery: after REQ-035, the "abc" block with in_first=0 -> the same digest as REQ-031.
REQ-037 Repeat REQ-031 with UNROLL=2, 4 and 8 -> identical digest at cycles 34, 18 and 10.
